// File: rtl/dmem_bridge.sv
// dmem_bridge: data-memory bridge between the MEM pipeline stage and the
// DRAM/peripheral bus.
//   - Loads wait READ_LATENCY cycles for bus data while holding the pipeline
//     with stall. The result is then extracted and sign- or zero-extended.
//   - Stores complete in one cycle. The store data is replicated across the
//     byte lanes and the matching byte enables are driven.
//   - A misaligned access is either dropped with a misalign_err pulse
//     (ALIGN_CHECK=1) or forced to natural alignment (ALIGN_CHECK=0).
//   - flush kills an in-flight load.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/wen/size/unsigned/addr/wdata   MEM-stage request
//   flush                              kill the in-flight load
//   stall, load_valid, load_data       pipeline handshake and load result
//   misalign_err                       one-cycle misalignment pulse
//   perip_addr/ren/wen/mask/byte_en/wdata, perip_rdata   bus side
module dmem_bridge #(
   parameter int READ_LATENCY = 1,
   parameter bit ALIGN_CHECK  = 1'b1,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_wen,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic              flush,
   output logic              stall,
   output logic              load_valid,
   output logic [31:0]       load_data,
   output logic              misalign_err,
   output logic [ADDR_W-1:0] perip_addr,
   output logic              perip_ren,
   output logic              perip_wen,
   output logic [1:0]        perip_mask,
   output logic [3:0]        perip_byte_en,
   output logic [31:0]       perip_wdata,
   input  logic [31:0]       perip_rdata
);

   localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(READ_LATENCY);

   typedef enum logic {IDLE, RD_WAIT} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;

   logic              stall_c, lv_c, mis_c, ren_c, wen_c;
   logic [31:0]       ld_c, wdata_c;
   logic [ADDR_W-1:0] addr_c, req_eff_addr;
   logic [1:0]        mask_c;
   logic [3:0]        be_c;
   logic              req_mis;

   // Size code 11 behaves as a word everywhere.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      return ((size == 2'b01) && lo[0]) || (size[1] && (lo != 2'b00));
   endfunction

   function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a, input logic [1:0] size);
      logic [ADDR_W-1:0] r;
      r = a;
      if (size == 2'b01) r[0] = 1'b0;
      else if (size[1]) r[1:0] = 2'b00;
      return r;
   endfunction

   function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] m;
      case (size)
         2'b00:   m = 4'b0001 << lo;
         2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] store_data(input logic [31:0] wd, input logic [1:0] size);
      logic [31:0] r;
      case (size)
         2'b00:   r = {4{wd[7:0]}};
         2'b01:   r = {2{wd[15:0]}};
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] size,
                                           input logic uns, input logic [1:0] lo);
      logic [31:0] sh;
      logic [31:0] r;
      sh = rd >> {lo, 3'b000};
      case (size)
         2'b00:   r = {{24{sh[7] & ~uns}}, sh[7:0]};
         2'b01:   r = {{16{sh[15] & ~uns}}, sh[15:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      stall_c = 1'b0;
      lv_c    = 1'b0;
      mis_c   = 1'b0;
      ren_c   = 1'b0;
      wen_c   = 1'b0;
      ld_c    = '0;
      wdata_c = '0;
      addr_c  = '0;
      mask_c  = '0;
      be_c    = '0;
      req_mis = is_misaligned(req_size, req_addr[1:0]);
      // With alignment checking on, a surviving request is already aligned,
      // so forcing alignment is a no-op there.
      req_eff_addr = align_addr(req_addr, req_size);

      case (state_q)
         IDLE: begin
            if (req_valid && !flush) begin
               if (ALIGN_CHECK && req_mis) begin
                  mis_c = 1'b1;
               end else begin
                  addr_c = req_eff_addr;
                  mask_c = req_size;
                  be_c   = lane_mask(req_size, req_eff_addr[1:0]);
                  if (req_wen) begin
                     wen_c   = 1'b1;
                     wdata_c = store_data(req_wdata, req_size);
                  end else begin
                     ren_c = 1'b1;
                     if (READ_LATENCY == 0) begin
                        lv_c = 1'b1;
                        ld_c = extract(perip_rdata, req_size, req_unsigned, req_eff_addr[1:0]);
                     end else begin
                        stall_c = 1'b1;
                        addr_d  = req_eff_addr;
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        cnt_d   = CNT_W'(1);
                        state_d = RD_WAIT;
                     end
                  end
               end
            end
         end
         RD_WAIT: begin
            if (flush) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               // The bus keeps seeing the captured access, even if the
               // pipeline's request inputs wander while stalled.
               addr_c = addr_q;
               mask_c = size_q;
               be_c   = lane_mask(size_q, addr_q[1:0]);
               if (cnt_q < LAT_C) begin
                  ren_c   = 1'b1;
                  stall_c = 1'b1;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else begin
                  lv_c    = 1'b1;
                  ld_c    = extract(perip_rdata, size_q, uns_q, addr_q[1:0]);
                  cnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced low while reset is held, even though some of them
   // are combinational functions of the request inputs.
   always_comb begin
      stall         = rst_n & stall_c;
      load_valid    = rst_n & lv_c;
      misalign_err  = rst_n & mis_c;
      perip_ren     = rst_n & ren_c;
      perip_wen     = rst_n & wen_c;
      load_data     = rst_n ? ld_c    : '0;
      perip_addr    = rst_n ? addr_c  : '0;
      perip_mask    = rst_n ? mask_c  : '0;
      perip_byte_en = rst_n ? be_c    : '0;
      perip_wdata   = rst_n ? wdata_c : '0;
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Testbench for dmem_bridge: four instances covering latencies 0/1/3/2 and
// both alignment policies, directed scenarios plus randomized accesses
// checked against a byte-level reference model.
module tb_dmem_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_valid [4];
   logic        req_wen [4];
   logic [1:0]  req_size [4];
   logic        req_unsigned [4];
   logic [31:0] req_addr [4];
   logic [31:0] req_wdata [4];
   logic        flush [4];
   logic [31:0] perip_rdata [4];

   logic        stall_o [4];
   logic        load_valid_o [4];
   logic [31:0] load_data_o [4];
   logic        misalign_o [4];
   logic [31:0] paddr_o [4];
   logic        pren_o [4];
   logic        pwen_o [4];
   logic [1:0]  pmask_o [4];
   logic [3:0]  pbe_o [4];
   logic [31:0] pwdata_o [4];

   int lat_tab [4] = '{0, 1, 3, 2};
   bit ac_tab [4]  = '{1'b1, 1'b1, 1'b1, 1'b0};

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int LG = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 2;
      localparam bit AG = (g == 3) ? 1'b0 : 1'b1;
      dmem_bridge #(.READ_LATENCY(LG), .ALIGN_CHECK(AG), .ADDR_W(32)) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .req_valid    (req_valid[g]),
         .req_wen      (req_wen[g]),
         .req_size     (req_size[g]),
         .req_unsigned (req_unsigned[g]),
         .req_addr     (req_addr[g]),
         .req_wdata    (req_wdata[g]),
         .flush        (flush[g]),
         .stall        (stall_o[g]),
         .load_valid   (load_valid_o[g]),
         .load_data    (load_data_o[g]),
         .misalign_err (misalign_o[g]),
         .perip_addr   (paddr_o[g]),
         .perip_ren    (pren_o[g]),
         .perip_wen    (pwen_o[g]),
         .perip_mask   (pmask_o[g]),
         .perip_byte_en(pbe_o[g]),
         .perip_wdata  (pwdata_o[g]),
         .perip_rdata  (perip_rdata[g])
      );
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] size,
                                            input logic uns, input logic [1:0] off);
      longint v;
      int nb;
      nb = nbytes(size);
      v = longint'(rd) >> (8 * off);
      v = v & ((64'd1 << (8 * nb)) - 1);
      if (!uns && (((v >> (8 * nb - 1)) & 1) == 1)) v = v - (64'd1 << (8 * nb));
      return v[31:0];
   endfunction

   function automatic logic [3:0] exp_lanes(input logic [1:0] size, input logic [1:0] off);
      int m;
      m = ((1 << nbytes(size)) - 1) << off;
      return m[3:0];
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] size);
      if (size == 2'b00) return {24'd0, wd[7:0]} * 32'h0101_0101;
      if (size == 2'b01) return {16'd0, wd[15:0]} * 32'h0001_0001;
      return wd;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 4; k++) begin
         req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_size[k] = 2'b00;
         req_unsigned[k] = 1'b0; req_addr[k] = '0; req_wdata[k] = '0;
         flush[k] = 1'b0; perip_rdata[k] = '0;
      end
   endtask

   task automatic all_zero(input string tag);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("%s u%0d stall", tag, k), 32'(stall_o[k]), 0);
         check($sformatf("%s u%0d load_valid", tag, k), 32'(load_valid_o[k]), 0);
         check($sformatf("%s u%0d load_data", tag, k), load_data_o[k], 0);
         check($sformatf("%s u%0d misalign", tag, k), 32'(misalign_o[k]), 0);
         check($sformatf("%s u%0d bus", tag, k),
               paddr_o[k] | 32'(pren_o[k]) | 32'(pwen_o[k]) | 32'(pmask_o[k])
               | 32'(pbe_o[k]) | pwdata_o[k], 0);
      end
   endtask

   task automatic idle_chk(input int k);
      @(negedge clk);
      check($sformatf("u%0d idle stall", k), 32'(stall_o[k]), 0);
      check($sformatf("u%0d idle load_valid", k), 32'(load_valid_o[k]), 0);
      check($sformatf("u%0d idle ren/wen", k), {30'd0, pren_o[k], pwen_o[k]}, 0);
      check($sformatf("u%0d idle addr", k), paddr_o[k], 0);
      check($sformatf("u%0d idle mask/be", k), {26'd0, pmask_o[k], pbe_o[k]}, 0);
      check($sformatf("u%0d idle wdata", k), pwdata_o[k], 0);
      next_cycle();
   endtask

   // One access on instance k, entered and left at posedge+1.  flush_at
   // selects the wait cycle (1..L) in which flush is raised; 0 = never.
   task automatic do_access(input int k, input logic wen, input logic [1:0] size,
                            input logic uns, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int flush_at);
      int L, nb;
      logic mis;
      logic [31:0] eff;
      string p;
      p   = $sformatf("u%0d", k);
      L   = lat_tab[k];
      nb  = nbytes(size);
      mis = ((nb == 2) && addr[0]) || ((nb == 4) && (addr[1:0] != 2'b00));
      eff = addr & ~32'(nb - 1);
      req_valid[k] = 1'b1; req_wen[k] = wen; req_size[k] = size;
      req_unsigned[k] = uns; req_addr[k] = addr; req_wdata[k] = wd;
      perip_rdata[k] = (L == 0) ? rd : $urandom;
      @(negedge clk);
      check({p, " misalign"}, 32'(misalign_o[k]), 32'(ac_tab[k] && mis));
      if (ac_tab[k] && mis) begin
         check({p, " mis ren/wen"}, {30'd0, pren_o[k], pwen_o[k]}, 0);
         check({p, " mis stall"}, 32'(stall_o[k]), 0);
         check({p, " mis load_valid"}, 32'(load_valid_o[k]), 0);
         next_cycle();
         req_valid[k] = 1'b0;
         return;
      end
      check({p, " addr"}, paddr_o[k], eff);
      check({p, " mask"}, 32'(pmask_o[k]), 32'(size));
      check({p, " byte_en"}, 32'(pbe_o[k]), 32'(exp_lanes(size, eff[1:0])));
      if (wen) begin
         check({p, " st ren/wen"}, {30'd0, pren_o[k], pwen_o[k]}, 32'b01);
         check({p, " st wdata"}, pwdata_o[k], exp_wdata(wd, size));
         check({p, " st stall/lv"}, {30'd0, stall_o[k], load_valid_o[k]}, 0);
         next_cycle();
         req_valid[k] = 1'b0;
         return;
      end
      check({p, " ld ren/wen"}, {30'd0, pren_o[k], pwen_o[k]}, 32'b10);
      check({p, " ld stall"}, 32'(stall_o[k]), 32'(L != 0));
      check({p, " ld load_valid"}, 32'(load_valid_o[k]), 32'(L == 0));
      if (L == 0) begin
         check({p, " ld data"}, load_data_o[k], exp_load(rd, size, uns, eff[1:0]));
         next_cycle();
         req_valid[k] = 1'b0;
         return;
      end
      for (int c = 1; c <= L; c++) begin
         next_cycle();
         perip_rdata[k] = (c == L) ? rd : $urandom;
         if (c == flush_at) flush[k] = 1'b1;
         @(negedge clk);
         if (c == flush_at) begin
            check({p, " flush stall"}, 32'(stall_o[k]), 0);
            check({p, " flush load_valid"}, 32'(load_valid_o[k]), 0);
            next_cycle();
            flush[k] = 1'b0;
            req_valid[k] = 1'b0;
            return;
         end
         if (c < L) begin
            check({p, " wait stall"}, 32'(stall_o[k]), 1);
            check({p, " wait ren"}, 32'(pren_o[k]), 1);
            check({p, " wait addr"}, paddr_o[k], eff);
            check({p, " wait load_valid"}, 32'(load_valid_o[k]), 0);
         end else begin
            check({p, " done stall"}, 32'(stall_o[k]), 0);
            check({p, " done load_valid"}, 32'(load_valid_o[k]), 1);
            check({p, " done data"}, load_data_o[k], exp_load(rd, size, uns, eff[1:0]));
         end
      end
      next_cycle();
      req_valid[k] = 1'b0;
   endtask

   // Request presented together with flush while idle must be ignored.
   task automatic flush_idle(input int k);
      req_valid[k] = 1'b1; req_wen[k] = $urandom_range(0, 1); req_size[k] = 2'b10;
      req_addr[k] = 32'h40; req_wdata[k] = $urandom; flush[k] = 1'b1;
      @(negedge clk);
      check($sformatf("u%0d fl-idle ren/wen", k), {30'd0, pren_o[k], pwen_o[k]}, 0);
      check($sformatf("u%0d fl-idle stall/lv", k), {30'd0, stall_o[k], load_valid_o[k]}, 0);
      next_cycle();
      req_valid[k] = 1'b0; flush[k] = 1'b0;
      idle_chk(k);
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #2;
      all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      for (int k = 0; k < 4; k++) idle_chk(k);

      // Sign/zero-extended byte loads with one wait cycle.
      do_access(1, 1'b0, 2'b00, 1'b0, 32'h103, 0, 32'h8899_AABB, 0);
      do_access(1, 1'b0, 2'b00, 1'b1, 32'h103, 0, 32'h8899_AABB, 0);
      // Half load with three wait cycles.
      do_access(2, 1'b0, 2'b01, 1'b0, 32'h202, 0, 32'h7F01_0000, 0);
      // Stores.
      do_access(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00A5, 0, 0);
      do_access(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 0);
      do_access(2, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234_5678, 0, 0);
      // Misaligned word load: dropped vs forced aligned.
      do_access(1, 1'b0, 2'b10, 1'b0, 32'h6, 0, 32'h1122_3344, 0);
      idle_chk(1);
      do_access(3, 1'b0, 2'b10, 1'b0, 32'h6, 0, 32'h1122_3344, 0);
      // Flush one cycle after acceptance, then a back-to-back load.
      do_access(3, 1'b0, 2'b10, 1'b0, 32'h20, 0, 32'hCAFE_F00D, 1);
      do_access(3, 1'b0, 2'b01, 1'b0, 32'h22, 0, 32'h8001_0000, 0);
      for (int k = 0; k < 4; k++) flush_idle(k);

      // Reset in the middle of a three-cycle load.
      req_valid[2] = 1'b1; req_wen[2] = 1'b0; req_size[2] = 2'b10; req_addr[2] = 32'h300;
      req_valid[0] = 1'b1; req_wen[0] = 1'b0; req_size[0] = 2'b10; req_addr[0] = 32'h304;
      perip_rdata[0] = 32'h5555_AAAA;
      next_cycle();
      #2;
      rst_n = 1'b0;
      #1;
      all_zero("midreset");
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      next_cycle();
      for (int i = 0; i < 4; i++) idle_chk(2);
      do_access(0, 1'b0, 2'b10, 1'b0, 32'h304, 0, 32'h5555_AAAA, 0);

      // Randomized accesses.
      for (int i = 0; i < 300; i++) begin
         int k, fa;
         logic [1:0] sz;
         k  = $urandom_range(0, 3);
         sz = 2'($urandom_range(0, 3));
         fa = 0;
         if (lat_tab[k] > 0 && $urandom_range(0, 5) == 0) fa = $urandom_range(1, lat_tab[k]);
         do_access(k, 1'($urandom_range(0, 2) == 0), sz, 1'($urandom_range(0, 1)),
                   {$urandom_range(0, 255), 2'($urandom_range(0, 3))} & 32'hFFFF_FFFF,
                   $urandom, $urandom, fa);
         if ($urandom_range(0, 7) == 0) idle_chk(k);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Parametrised data-memory bridge between the MEM stage of the RV32 pipeline datapath and the DRAM/peripheral bus (perip_*).
- Replaces the fixed optional one-cycle read buffer with a configurable read latency and a pipeline stall handshake.
- Adds store byte-lane alignment, load extraction with sign/zero extension, misalignment detection, and flush of an in-flight load.

Parameters:
READ_LATENCY, 1, cycles from address presentation to valid perip_rdata; legal range 0..7
ALIGN_CHECK, 1, 1 = misaligned access raises misalign_err and is dropped; 0 = low address bits forced to natural alignment
ADDR_W, 32, address width

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  1  MEM-stage access request; held stable by the pipeline while stall=1
req_wen  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word; 11 is treated as word
req_unsigned  input  1  load zero-extends (LBU/LHU)
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-aligned
flush  input  1  kill the in-flight load
stall  output  1  freeze the pipeline while a load is pending
load_valid  output  1  load_data valid this cycle
load_data  output  32  extended load result
misalign_err  output  1  one-cycle pulse on a misaligned request
perip_addr  output  ADDR_W  bus address
perip_ren  output  1  bus read strobe
perip_wen  output  1  bus write strobe
perip_mask  output  2  size code; copy of req_size
perip_byte_en  output  4  active byte lanes
perip_wdata  output  32  lane-replicated store data
perip_rdata  input  32  bus read data

Behaviour:
- States: IDLE, RD_WAIT. Registers:
  - addr_q, size_q, uns_q, captured at load acceptance.
  - Counter cnt, width clog2(READ_LATENCY+1).
- Reset (rst_n=0, async): state=IDLE, cnt=0, captured registers=0.
  - Every output is 0 while rst_n=0, including stall, load_valid, load_data, misalign_err and all perip_* outputs.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
  - ALIGN_CHECK=1: misalign_err=1 for that cycle; no perip_ren/perip_wen; stall=0; load_valid=0.
  - ALIGN_CHECK=0: perip_addr forced aligned (half clears bit 0, word clears bits 1:0); no error.
- Store (IDLE, req_valid & req_wen, aligned):
  - Single cycle; perip_wen=1, perip_addr=req_addr, stall=0.
  - Byte: wdata={4{b}}, byte_en=1<<addr[1:0].
  - Half: wdata={2{h}}, byte_en=0011 or 1100 by addr[1].
  - Word: byte_en=1111.
- Load with READ_LATENCY=0: fully combinational in the request cycle.
  - perip_ren=1, load_valid=1, stall=0.
- Load with READ_LATENCY=L≥1:
  - Acceptance cycle (IDLE): bus driven from req_* inputs; perip_ren=1; stall=1; capture registers; cnt←1; go to RD_WAIT.
  - RD_WAIT, cnt<L: bus driven from captured registers; perip_ren=1; stall=1; cnt++.
  - RD_WAIT, cnt==L: load_valid=1; stall=0; go to IDLE. A new request can be accepted in the following cycle.
  - Net effect: exactly L stall cycles per load.
- Extraction: shift perip_rdata right by 8*addr[1:0]; take byte/half/word; sign-extend unless the unsigned flag is set. Uses captured fields when L≥1.
- perip_mask mirrors the active size; it is 0 when idle.
- Idle with no request: perip_ren=perip_wen=0; perip_addr=0; byte_en=0; wdata=0.
- Flush:
  - flush=1 in RD_WAIT: next state IDLE, cnt=0, no load_valid. stall is 0 in the flush cycle.
  - flush=1 together with a new request in IDLE: the request is ignored.
- Stores never enter RD_WAIT. req_valid changing during RD_WAIT is a protocol violation; the bridge uses captured values.
- Reset asserted mid-load returns to IDLE immediately; no load_valid is produced.

Test Plan:
- L=1, perip_rdata=0x8899AABB, LB addr 0x103 -> 1 stall cycle, then load_valid=1, load_data=0xFFFFFF88; LBU -> 0x00000088.
- L=3, LH addr 0x202, rdata=0x7F01_0000 -> stall=1 for exactly 3 cycles, perip_addr=0x202 held, then load_data=0x00007F01.
- SB 0xA5 to addr 0x11 -> single cycle, perip_wen=1, byte_en=0010, wdata=0xA5A5A5A5, stall=0; SW to 0x10 -> byte_en=1111.
- ALIGN_CHECK=1, LW addr 0x6 -> misalign_err pulse, perip_ren=0, stall=0; ALIGN_CHECK=0 -> perip_addr=0x4, normal load.
- L=2: flush one cycle after acceptance -> no load_valid, state IDLE; back-to-back load accepted next cycle with correct result.
- rst_n pulsed low during RD_WAIT (L=3) -> all outputs 0 immediately; after release no spurious load_valid; L=0 LW returns data same cycle.
